// File: rtl/uart_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo_core : buffered UART, configurable framing, 16x RX, FIFOs   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+

module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [LW-1:0]    level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  // Full/empty are judged from the registered level, so a pop never makes room for a same-cycle push.
  always_comb begin
    wr_ready = (level_q != LW'(DEPTH));
    rd_valid = (level_q != '0);
    push     = wr_valid && wr_ready;
    pop      = rd_ready && rd_valid;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    level    = level_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module uart_fifo_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 err_clear,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level
);
  localparam int             DIV       = CLK_FREQ / (BAUD * 16);
  localparam int             DW        = $clog2(DIV);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  // ---------------- tick generator ----------------
  logic [DW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == DIV_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + DW'(1);
  end

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_head_valid, tx_pop;
  logic                 rx_push, rx_fifo_ready;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk(sys_clk), .rst_n(rst_n),
    .wr_data(tx_data), .wr_valid(tx_valid), .wr_ready(tx_ready),
    .rd_data(tx_head), .rd_valid(tx_head_valid), .rd_ready(tx_pop),
    .level(tx_level)
  );

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk(sys_clk), .rst_n(rst_n),
    .wr_data(rx_shift_q), .wr_valid(rx_push), .wr_ready(rx_fifo_ready),
    .rd_data(rx_data), .rd_valid(rx_valid), .rd_ready(rx_ready),
    .level(rx_level)
  );

  // ---------------- transmitter ----------------
  state_t               tx_state_q, tx_state_d;
  logic [3:0]           tx_smp_q, tx_smp_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_smp_d   = tx_smp_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    if (tick) begin
      tx_smp_d = tx_smp_q + 4'd1;
      unique case (tx_state_q)
        ST_IDLE: tx_load = tx_head_valid;
        ST_START: begin
          if (tx_smp_q == 4'd15) begin
            tx_state_d = ST_DATA;
            tx_bit_d   = '0;
            tx_d       = tx_shift_q[0];
          end
        end
        ST_DATA: begin
          if (tx_smp_q == 4'd15) begin
            if (tx_bit_q == LAST_BIT) begin
              tx_stop_d = 1'b0;
              if (PARITY != 0) begin
                tx_state_d = ST_PARITY;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = ST_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = tx_shift_q >> 1;
              tx_d       = tx_shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tx_smp_q == 4'd15) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_smp_q == 4'd15) begin
            if (tx_stop_q == LAST_STOP) begin
              tx_state_d = ST_IDLE;
              tx_load    = tx_head_valid;
            end else begin
              tx_stop_d = tx_stop_q + 1'b1;
            end
          end
        end
        default: tx_state_d = ST_IDLE;
      endcase
      // A queued word chains straight into the next start bit.
      if (tx_load) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_head;
        tx_par_d   = (^tx_head) ^ PAR_ODD;
        tx_smp_d   = '0;
        tx_state_d = ST_START;
        tx_d       = 1'b0;
      end
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != ST_IDLE) || tx_head_valid;

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_t               rx_state_q, rx_state_d;
  logic [DW-1:0]        rx_div_q, rx_div_d;
  logic [3:0]           rx_smp_q, rx_smp_d;
  logic [1:0]           rx_ones_q, rx_ones_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic                 rx_stop_q, rx_stop_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_bad_q, rx_bad_d;
  logic                 rx_tick, rx_vote;
  logic                 fe_set, pe_set, ov_set;
  logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_smp_d   = rx_smp_q;
    rx_ones_d  = rx_ones_q;
    rx_bit_d   = rx_bit_q;
    rx_stop_d  = rx_stop_q;
    rx_par_d   = rx_par_q;
    rx_bad_d   = rx_bad_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    pe_set     = 1'b0;
    ov_set     = 1'b0;
    rx_tick    = (rx_div_q == DIV_LAST);
    rx_vote    = (rx_ones_q + {1'b0, rx_sync_q}) >= 2'd2;
    if (rx_state_q == ST_IDLE) begin
      rx_div_d  = '0;
      rx_smp_d  = '0;
      rx_ones_d = '0;
      rx_bad_d  = 1'b0;
      if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
    end else if (rx_state_q == ST_BREAK) begin
      if (rx_sync_q) rx_state_d = ST_IDLE;
    end else begin
      rx_div_d = rx_tick ? '0 : rx_div_q + DW'(1);
      if (rx_tick) begin
        rx_smp_d = rx_smp_q + 4'd1;
        if (rx_smp_q == 4'd6 || rx_smp_q == 4'd7) rx_ones_d = rx_ones_q + {1'b0, rx_sync_q};
        // Third of three mid-bit samples: resolve the bit by majority.
        if (rx_smp_q == 4'd8) begin
          rx_ones_d = '0;
          unique case (rx_state_q)
            ST_START:  if (rx_vote) rx_state_d = ST_IDLE;
            ST_DATA:   rx_shift_d = {rx_vote, rx_shift_q[DATA_BITS-1:1]};
            ST_PARITY: rx_par_d = rx_vote;
            ST_STOP: begin
              if (rx_stop_q == LAST_STOP) begin
                rx_state_d = ST_IDLE;
                if (rx_bad_q || !rx_vote) begin
                  fe_set     = 1'b1;
                  rx_state_d = ST_BREAK;
                end else if (PARITY != 0 && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD))) begin
                  pe_set = 1'b1;
                end else if (!rx_fifo_ready) begin
                  ov_set = 1'b1;
                end else begin
                  rx_push = 1'b1;
                end
              end else if (!rx_vote) begin
                rx_bad_d = 1'b1;
              end
            end
            default: rx_state_d = ST_IDLE;
          endcase
        end
        if (rx_smp_q == 4'd15) begin
          unique case (rx_state_q)
            ST_START: begin
              rx_state_d = ST_DATA;
              rx_bit_d   = '0;
            end
            ST_DATA: begin
              if (rx_bit_q == LAST_BIT) begin
                rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                rx_stop_d  = 1'b0;
              end else begin
                rx_bit_d = rx_bit_q + 3'd1;
              end
            end
            ST_PARITY: begin
              rx_state_d = ST_STOP;
              rx_stop_d  = 1'b0;
            end
            ST_STOP: rx_stop_d = rx_stop_q + 1'b1;
            default: rx_state_d = ST_IDLE;
          endcase
        end
      end
    end
    // A new error wins over a same-cycle clear.
    fe_d = fe_set || (fe_q && !err_clear);
    pe_d = pe_set || (pe_q && !err_clear);
    ov_d = ov_set || (ov_q && !err_clear);
  end

  assign rx_frame_err  = fe_q;
  assign rx_parity_err = pe_q;
  assign rx_overrun    = ov_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tx_state_q <= ST_IDLE;
      tx_smp_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_div_q   <= '0;
      rx_smp_q   <= '0;
      rx_ones_q  <= '0;
      rx_bit_q   <= '0;
      rx_stop_q  <= 1'b0;
      rx_par_q   <= 1'b0;
      rx_bad_q   <= 1'b0;
      rx_shift_q <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tx_state_q <= tx_state_d;
      tx_smp_q   <= tx_smp_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_smp_q   <= rx_smp_d;
      rx_ones_q  <= rx_ones_d;
      rx_bit_q   <= rx_bit_d;
      rx_stop_q  <= rx_stop_d;
      rx_par_q   <= rx_par_d;
      rx_bad_q   <= rx_bad_d;
      rx_shift_q <= rx_shift_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ov_q       <= ov_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_fifo_core : directed bench, instance A = 8N1, B = 7 bits even |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_uart_fifo_core;
  localparam int CLK_FREQ = 7372800;   // 16 * 115200 * 4 -> DIV = 4
  localparam int BAUD     = 115200;
  localparam int BIT      = 64;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  logic rst_n;

  logic [7:0] a_tx_data, a_rx_data;
  logic       a_tx_valid, a_tx_ready, a_tx, a_tx_busy, a_rx;
  logic       a_rx_valid, a_rx_ready, a_fe, a_pe, a_ov, a_err_clear;
  logic [4:0] a_tx_level, a_rx_level;
  logic       a_loop, a_drv;
  assign a_rx = a_loop ? a_tx : a_drv;

  logic [6:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_tx, b_tx_busy, b_rx;
  logic       b_rx_valid, b_rx_ready, b_fe, b_pe, b_ov, b_err_clear;
  logic [4:0] b_tx_level, b_rx_level;
  logic       b_loop, b_drv;
  assign b_rx = b_loop ? b_tx : b_drv;

  uart_fifo_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .tx_busy(a_tx_busy), .rx(a_rx),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov),
    .err_clear(a_err_clear), .tx_level(a_tx_level), .rx_level(a_rx_level)
  );

  uart_fifo_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx(b_tx), .tx_busy(b_tx_busy), .rx(b_rx),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov),
    .err_clear(b_err_clear), .tx_level(b_tx_level), .rx_level(b_rx_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock cycles; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_line(input bit sel_b, input logic v);
    if (sel_b) b_drv = v;
    else       a_drv = v;
  endtask

  task automatic drive_frame(input bit sel_b, input logic [7:0] d, input int nbits,
                             input bit par_en, input logic par_bit, input logic stop_bit);
    set_line(sel_b, 1'b0);
    cyc(BIT);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel_b, d[i]);
      cyc(BIT);
    end
    if (par_en) begin
      set_line(sel_b, par_bit);
      cyc(BIT);
    end
    set_line(sel_b, stop_bit);
    cyc(BIT);
    set_line(sel_b, 1'b1);
  endtask

  task automatic pop_a();
    a_rx_ready = 1'b1;
    cyc(1);
    a_rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    a_err_clear = 1'b1;
    b_err_clear = 1'b1;
    cyc(1);
    a_err_clear = 1'b0;
    b_err_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1279:0] samp;
    logic [19:0]   a_bits;
    logic [9:0]    b_bits;
    int            lat, run, k;

    rst_n = 1'b0;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b0; a_err_clear = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0; b_err_clear = 1'b0;
    a_loop = 1'b1; a_drv = 1'b1; b_loop = 1'b1; b_drv = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Reset state
    chk("rst_a_outs", {a_tx, a_tx_busy, a_tx_ready, a_rx_valid, a_fe, a_pe, a_ov}, 7'b1010000);
    chk("rst_a_levels", {a_tx_level, a_rx_level}, 10'd0);
    chk("rst_a_rx_data", a_rx_data, 8'h00);
    chk("rst_b_outs", {b_tx, b_tx_busy, b_tx_ready, b_rx_valid, b_fe, b_pe, b_ov}, 7'b1010000);

    // Loopback 8N1: 0x55 then 0xA5
    a_tx_data = 8'h55; a_tx_valid = 1'b1;
    cyc(1);
    chk("tx_level_after_push", a_tx_level, 5'd1);
    chk("tx_busy_after_push", a_tx_busy, 1'b1);
    a_tx_data = 8'hA5;
    lat = 0;
    while (lat < 20 && a_tx) begin
      cyc(1);
      lat++;
      if (lat == 1) a_tx_valid = 1'b0;
    end
    chk("tx_start_latency_le_5", lat <= 5, 1'b1);
    samp[0] = a_tx;
    for (int i = 1; i < 1280; i++) begin
      cyc(1);
      samp[i] = a_tx;
    end
    run = 0;
    while (run < 1280 && samp[run] == 1'b0) run++;
    chk("start_bit_low_cycles", run, 64);
    chk("b2b_stop_then_start", {samp[639], samp[640]}, 2'b10);
    for (int i = 0; i < 20; i++) a_bits[i] = samp[32 + 64 * i];
    chk("a_line_bits", a_bits, {1'b1, 8'hA5, 1'b0, 1'b1, 8'h55, 1'b0});
    cyc(2);
    chk("tx_busy_after_frames", a_tx_busy, 1'b0);
    k = 0;
    while (k < 300 && a_rx_level != 5'd2) begin cyc(1); k++; end
    chk("loop_rx_level", a_rx_level, 5'd2);
    chk("loop_rx_word0", a_rx_data, 8'h55);
    pop_a();
    chk("loop_rx_word1", a_rx_data, 8'hA5);
    pop_a();
    chk("loop_rx_empty", a_rx_valid, 1'b0);

    // 7 data bits, even parity: 0x35 has four ones -> parity bit 0
    b_tx_data = 7'h35; b_tx_valid = 1'b1;
    cyc(1);
    b_tx_valid = 1'b0;
    k = 0;
    while (k < 20 && b_tx) begin cyc(1); k++; end
    cyc(32);
    b_bits[0] = b_tx;
    for (int i = 1; i < 10; i++) begin
      cyc(BIT);
      b_bits[i] = b_tx;
    end
    chk("b_line_bits", b_bits, {1'b1, 1'b0, 7'h35, 1'b0});
    chk("b_parity_bit", b_bits[8], 1'b0);
    k = 0;
    while (k < 200 && !b_rx_valid) begin cyc(1); k++; end
    chk("b_rx_word", b_rx_data, 7'h35);
    chk("b_no_parity_err", b_pe, 1'b0);
    b_rx_ready = 1'b1; cyc(1); b_rx_ready = 1'b0;

    b_loop = 1'b0;
    drive_frame(1'b1, 8'h35, 7, 1'b1, 1'b1, 1'b1);
    cyc(BIT);
    chk("b_parity_err_set", b_pe, 1'b1);
    chk("b_parity_word_dropped", b_rx_level, 5'd0);
    pulse_clear();
    chk("b_parity_err_cleared", b_pe, 1'b0);

    // Frame error then recovery
    a_loop = 1'b0;
    drive_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    cyc(2 * BIT);
    chk("a_frame_err_set", a_fe, 1'b1);
    chk("a_frame_word_dropped", a_rx_level, 5'd0);
    drive_frame(1'b0, 8'h11, 8, 1'b0, 1'b0, 1'b1);
    cyc(8);
    chk("a_after_ferr_valid", a_rx_valid, 1'b1);
    chk("a_after_ferr_word", a_rx_data, 8'h11);
    chk("a_frame_err_sticky", a_fe, 1'b1);
    pop_a();
    pulse_clear();
    chk("a_frame_err_cleared", a_fe, 1'b0);

    // Overrun: 17 frames into a 16-deep RX FIFO, nobody popping
    for (int w = 1; w <= 17; w++) drive_frame(1'b0, 8'(w), 8, 1'b0, 1'b0, 1'b1);
    cyc(8);
    chk("ovr_rx_level", a_rx_level, 5'd16);
    chk("ovr_flag", a_ov, 1'b1);
    chk("ovr_no_frame_err", a_fe, 1'b0);
    for (int w = 1; w <= 16; w++) begin
      chk($sformatf("ovr_word_%0d", w), a_rx_data, 32'(w));
      pop_a();
    end
    chk("ovr_drained", a_rx_valid, 1'b0);
    pulse_clear();

    // TX FIFO boundary
    a_loop = 1'b1;
    a_tx_data = 8'hF0; a_tx_valid = 1'b1;
    cyc(1);
    a_tx_valid = 1'b0;
    k = 0;
    while (k < 20 && a_tx) begin cyc(1); k++; end
    a_tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_tx_data = 8'(i);
      cyc(1);
    end
    chk("txf_level_full", a_tx_level, 5'd16);
    chk("txf_ready_low", a_tx_ready, 1'b0);
    a_tx_data = 8'hEE;
    k = 0;
    while (k < 1000 && a_tx_level != 5'd15) begin cyc(1); k++; end
    chk("txf_pop_not_refilled_same_cycle", a_tx_level, 5'd15);
    cyc(1);
    a_tx_valid = 1'b0;
    chk("txf_refill_next_cycle", a_tx_level, 5'd16);

    // Reset mid-DATA on both paths (frame carrying 0x00 is on the wire)
    cyc(200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx_high", a_tx, 1'b1);
    chk("rst_async_levels", {a_tx_level, a_rx_level}, 10'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_mid_outs", {a_tx, a_tx_busy, a_tx_ready, a_rx_valid, a_fe, a_pe, a_ov}, 7'b1010000);
    chk("rst_mid_levels", {a_tx_level, a_rx_level}, 10'd0);

    // Short low glitch on rx: false start, nothing recorded
    a_loop = 1'b0;
    a_drv = 1'b0;
    cyc(20);
    a_drv = 1'b1;
    cyc(11 * BIT);
    chk("glitch_no_word", a_rx_level, 5'd0);
    chk("glitch_no_flags", {a_fe, a_pe, a_ov}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
